// File: rtl/axi4stream_fifo.sv
// -----------------------------------------------------------------------------
// axi4stream_fifo
//   First-word-fall-through AXI4-Stream FIFO. Absorbs bursts up to DEPTH beats
//   between a stream producer (slave side) and a stream consumer (master side).
//
// Ports
//   i_clk        single clock, rising edge
//   i_rst        asynchronous, active-low reset
//   i_s_tvalid   upstream beat valid
//   o_s_tready   FIFO accepts a beat this cycle (registered)
//   i_s_tdata    upstream beat data [DW]
//   o_m_tvalid   head beat valid (registered)
//   i_m_tready   downstream accepts the head beat
//   o_m_tdata    head beat data [DW], read straight out of storage
//   o_level      number of stored beats, 0..DEPTH [AW+1]
// -----------------------------------------------------------------------------
module axi4stream_fifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_s_tvalid,
    output logic          o_s_tready,
    input  logic [DW-1:0] i_s_tdata,
    output logic          o_m_tvalid,
    input  logic          i_m_tready,
    output logic [DW-1:0] o_m_tdata,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_s_tready;
    logic          r_m_tvalid;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_level_nxt;

    // Handshakes qualify on the registered flags only, so a full FIFO can
    // never push and an empty one can never pop.
    assign w_push = i_s_tvalid & r_s_tready;
    assign w_pop  = r_m_tvalid & i_m_tready;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + (AW+1)'(1);
            2'b01:   w_level_nxt = r_level - (AW+1)'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level    <= w_level_nxt;
            // Flags follow the post-edge level; this keeps m_tready out of
            // the s_tready timing path.
            r_s_tready <= (w_level_nxt != LVL_FULL);
            r_m_tvalid <= (w_level_nxt != '0);
        end
    end

    // Storage is not reset; a push cannot happen while reset holds s_tready low.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_s_tdata;
    end

    assign o_s_tready = r_s_tready;
    assign o_m_tvalid = r_m_tvalid;
    assign o_m_tdata  = r_mem[r_rd_ptr];
    assign o_level    = r_level;

endmodule

// File: tb/tb_axi4stream_fifo.sv
module tb_axi4stream_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [AW:0]   level;

    axi4stream_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_s_tvalid (s_tvalid),
        .o_s_tready (s_tready),
        .i_s_tdata  (s_tdata),
        .o_m_tvalid (m_tvalid),
        .i_m_tready (m_tready),
        .o_m_tdata  (m_tdata),
        .o_level    (level)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered queue of accepted beats plus the two
    // handshake flags as the consumer/producer should see them.
    logic [DW-1:0] q[$];
    bit            exp_srdy;
    bit            exp_mvld;
    bit            last_push;
    bit            last_pop;
    logic [DW-1:0] last_pop_data;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: model the handshake at the edge, then sample 1 time unit later.
    task automatic cyc();
        bit push, pop;
        push = s_tvalid && exp_srdy;
        pop  = exp_mvld && m_tready;
        last_pop_data = (q.size() != 0) ? q[0] : '0;
        @(posedge clk);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(s_tdata);
        last_push = push;
        last_pop  = pop;
        exp_srdy  = rst && (q.size() != DEPTH);
        exp_mvld  = rst && (q.size() != 0);
        #1;
        chk("s_tready", {63'd0, s_tready}, {63'd0, exp_srdy});
        chk("m_tvalid", {63'd0, m_tvalid}, {63'd0, exp_mvld});
        chk("level", 64'(level), 64'(q.size()));
        chk("level_max", 64'(level <= DEPTH), 64'd1);
        if (exp_mvld) chk("m_tdata", 64'(m_tdata), 64'(q[0]));
    endtask

    // Assert reset between edges and check the outputs clear without an edge.
    task automatic async_reset(input int hold);
        #2 rst = 1'b0;
        #1;
        q.delete();
        exp_srdy = 1'b0;
        exp_mvld = 1'b0;
        chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
        chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        repeat (hold) cyc();
        rst = 1'b1;
    endtask

    task automatic drain_all();
        int budget;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        budget = 0;
        while (q.size() != 0 && budget < 40) begin
            cyc();
            budget++;
        end
        chk("drain_done", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] val;
        int budget;
        int hold;

        rst      = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        exp_srdy = 1'b0;
        exp_mvld = 1'b0;

        // Reset, then fill 0x11..0x18 with the consumer stalled.
        #1;
        chk("por_s_tready", {63'd0, s_tready}, 64'd0);
        chk("por_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("por_level", 64'(level), 64'd0);
        repeat (3) cyc();
        rst = 1'b1;
        val = 32'h11;
        s_tvalid = 1'b1;
        s_tdata  = val;
        budget = 0;
        while (q.size() != DEPTH && budget < 20) begin
            cyc();
            if (last_push) begin
                val++;
                s_tdata = val;
            end
            budget++;
        end
        chk("fill_level", 64'(level), 64'(DEPTH));
        chk("fill_s_tready", {63'd0, s_tready}, 64'd0);
        s_tdata = 32'hFF;
        repeat (3) cyc();
        chk("full_no_accept", 64'(q[DEPTH-1]), 64'h18);

        // Drain: model verifies 0x11..0x18 in order, one per cycle.
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc();
            chk("drain_order", 64'(last_pop_data), 64'(32'h11 + i));
        end
        chk("drain_empty", {63'd0, m_tvalid}, 64'd0);

        // Simultaneous push/pop at full.
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_tdata = $urandom;
            cyc();
        end
        chk("full2_level", 64'(level), 64'(DEPTH));
        s_tdata  = 32'hAA;
        m_tready = 1'b1;
        cyc();
        chk("full_pop_only", 64'(level), 64'(DEPTH - 1));
        cyc();
        chk("push_pop_level", 64'(level), 64'(DEPTH - 1));
        chk("aa_queued_last", 64'(q[DEPTH-2]), 64'hAA);
        s_tvalid = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) cyc();
        chk("aa_out_last", 64'(last_pop_data), 64'hAA);

        // Wrap-around: 20 beats, consumer toggling ready.
        val = '0;
        s_tvalid = 1'b1;
        s_tdata  = val;
        budget = 0;
        hold = 0;
        while ((val < 20 || q.size() != 0) && budget < 200) begin
            m_tready = budget[0] ? 1'b0 : 1'b1;
            s_tvalid = (val < 20);
            cyc();
            if (last_pop) begin
                chk("wrap_order", 64'(last_pop_data), 64'(hold));
                hold++;
            end
            if (last_push) begin
                val++;
                s_tdata = val;
            end
            budget++;
        end
        chk("wrap_count", 64'(hold), 64'd20);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            s_tvalid = 1'($urandom);
            s_tdata  = $urandom;
            m_tready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain_all();

        // Backpressure: head must hold while stalled and pushing.
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'hC3C3_0001;
        cyc();
        for (int i = 0; i < 5; i++) begin
            s_tdata = 32'h5000 + i;
            cyc();
            chk("bp_m_tdata", 64'(m_tdata), 64'hC3C3_0001);
            chk("bp_m_tvalid", {63'd0, m_tvalid}, 64'd1);
        end
        drain_all();

        // Reset mid-operation at level 5.
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_tdata = 32'h700 + i;
            cyc();
        end
        chk("pre_rst_level", 64'(level), 64'd5);
        s_tvalid = 1'b0;
        async_reset(2);
        s_tvalid = 1'b1;
        s_tdata  = 32'h55;
        budget = 0;
        while (!last_push && budget < 5) begin
            cyc();
            budget++;
        end
        s_tdata  = 32'h66;
        cyc();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        cyc();
        chk("post_rst_first", 64'(last_pop_data), 64'h55);
        drain_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
